// File: rtl/button_conditioner.sv
// Input stage for the password-lock controller: synchronizes, debounces and
// edge-detects the four push-buttons, arbitrates to one command pulse per cycle.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_enter,
    input  logic       btn_set,
    input  logic       btn_change,
    input  logic       btn_reset,
    input  logic [3:0] hex_sw,
    output logic       enter,
    output logic       set,
    output logic       change,
    output logic       lock_reset,
    output logic [3:0] hex_in,
    output logic [3:0] held
);

    localparam int NB = 4;
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    // Bit order everywhere: {reset, set, change, enter}.
    logic [NB-1:0]    btn_raw;
    logic [NB-1:0]    btn_s1;
    logic [NB-1:0]    btn_s2;
    logic [NB-1:0]    db_q;
    logic [NB-1:0]    db_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [3:0]       hex_s1;
    logic [3:0]       hex_s2;
    logic [NB-1:0]    rise;
    logic [NB-1:0]    grant;

    assign btn_raw = {btn_reset, btn_set, btn_change, btn_enter};
    assign held    = db_q;

    // The level flips on the edge where the disagreement count would hit the limit.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (btn_s2[i] != db_q[i]) begin
                if (cnt_q[i] + CNT_W'(1) == DB_LIMIT) begin
                    db_d[i] = btn_s2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = db_d & ~db_q;

    // Losing rises are dropped; their levels are already high so they never re-fire.
    always_comb begin
        grant = '0;
        if (rise[3]) begin
            grant = 4'b1000;
        end else if (rise[2]) begin
            grant = 4'b0100;
        end else if (rise[1]) begin
            grant = 4'b0010;
        end else if (rise[0]) begin
            grant = 4'b0001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            db_q       <= '0;
            hex_s1     <= '0;
            hex_s2     <= '0;
            enter      <= 1'b0;
            set        <= 1'b0;
            change     <= 1'b0;
            lock_reset <= 1'b0;
            hex_in     <= 4'h0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_s1     <= btn_raw;
            btn_s2     <= btn_s1;
            db_q       <= db_d;
            hex_s1     <= hex_sw;
            hex_s2     <= hex_s1;
            enter      <= grant[0];
            change     <= grant[1];
            set        <= grant[2];
            lock_reset <= grant[3];
            if (grant[0]) begin
                hex_in <= hex_s2;
            end
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: pulse timing,
// glitch rejection, arbitration, hex capture and reset behaviour.
module tb_button_conditioner;

    logic       clk;
    logic       reset;
    logic       btn_enter;
    logic       btn_set;
    logic       btn_change;
    logic       btn_reset;
    logic [3:0] hex_sw;
    logic       enter;
    logic       set;
    logic       change;
    logic       lock_reset;
    logic [3:0] hex_in;
    logic [3:0] held;

    int n_checks;
    int n_pass;
    int cnt_e;
    int cnt_s;
    int cnt_c;
    int cnt_r;

    button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_enter (btn_enter),
        .btn_set   (btn_set),
        .btn_change(btn_change),
        .btn_reset (btn_reset),
        .hex_sw    (hex_sw),
        .enter     (enter),
        .set       (set),
        .change    (change),
        .lock_reset(lock_reset),
        .hex_in    (hex_in),
        .held      (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle; pulses seen after the edge are tallied.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt_e += int'(enter);
        cnt_s += int'(set);
        cnt_c += int'(change);
        cnt_r += int'(lock_reset);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        cnt_e = 0;
        cnt_s = 0;
        cnt_c = 0;
        cnt_r = 0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [3:0] digits [4];
        digits[0] = 4'h0;
        digits[1] = 4'hF;
        digits[2] = 4'hA;
        digits[3] = 4'h5;
        n_checks = 0;
        n_pass   = 0;
        clear_counts();

        reset      = 1'b1;
        btn_enter  = 1'b0;
        btn_set    = 1'b0;
        btn_change = 1'b0;
        btn_reset  = 1'b0;
        hex_sw     = 4'h0;
        run(3);
        check("reset_pulses", {4'h0, enter, set, change, lock_reset}, 8'h00);
        check("reset_hex_in", {4'h0, hex_in}, 8'h00);
        check("reset_held",   {4'h0, held}, 8'h00);

        // 1: held enter pulses once on the 6th edge, never repeats
        reset     = 1'b0;
        btn_enter = 1'b1;
        hex_sw    = 4'hF;
        clear_counts();
        run(5);
        check("t1_enter_early", {7'h0, enter}, 8'h00);
        check("t1_held_early",  {4'h0, held}, 8'h00);
        tick();
        check("t1_enter_pulse", {7'h0, enter}, 8'h01);
        check("t1_hex_in",      {4'h0, hex_in}, 8'h0F);
        check("t1_held",        {4'h0, held}, 8'h01);
        tick();
        check("t1_enter_one_cycle", {7'h0, enter}, 8'h00);
        clear_counts();
        run(50);
        check("t1_no_repeat", 8'(cnt_e), 8'd0);
        check("t1_held_still", {4'h0, held}, 8'h01);
        btn_enter = 1'b0;
        run(10);
        check("t1_release_held", {4'h0, held}, 8'h00);

        // 2: 3-cycle glitch rejected, 5-cycle press accepted
        clear_counts();
        btn_set = 1'b1;
        run(3);
        btn_set = 1'b0;
        run(12);
        check("t2_glitch_pulses", 8'(cnt_s), 8'd0);
        check("t2_glitch_held",   {7'h0, held[2]}, 8'h00);
        btn_set = 1'b1;
        run(5);
        btn_set = 1'b0;
        run(15);
        check("t2_press_pulses", 8'(cnt_s), 8'd1);
        check("t2_other_pulses", 8'(cnt_e + cnt_c + cnt_r), 8'd0);

        // 3: change beats enter on the same edge; hex_in untouched
        hex_sw    = 4'h5;
        btn_enter = 1'b1;
        run(8);
        btn_enter = 1'b0;
        run(10);
        check("t3_hex_pre", {4'h0, hex_in}, 8'h05);
        clear_counts();
        hex_sw     = 4'hA;
        btn_change = 1'b1;
        btn_enter  = 1'b1;
        run(10);
        check("t3_change_pulses", 8'(cnt_c), 8'd1);
        check("t3_enter_pulses",  8'(cnt_e), 8'd0);
        check("t3_hex_kept",      {4'h0, hex_in}, 8'h05);
        check("t3_held_both",     {4'h0, held}, 8'h03);
        btn_change = 1'b0;
        btn_enter  = 1'b0;
        run(10);
        btn_enter = 1'b1;
        run(5);
        check("t3_reenter_early", {7'h0, enter}, 8'h00);
        tick();
        check("t3_reenter_pulse", {7'h0, enter}, 8'h01);
        check("t3_reenter_hex",   {4'h0, hex_in}, 8'h0A);
        btn_enter = 1'b0;
        run(10);

        // 4: digit entry sequence 0, F, A, 5
        for (int d = 0; d < 4; d++) begin
            hex_sw    = digits[d];
            btn_enter = 1'b1;
            run(6);
            check($sformatf("t4_pulse_%0d", d), {7'h0, enter}, 8'h01);
            check($sformatf("t4_hex_%0d", d), {4'h0, hex_in}, {4'h0, digits[d]});
            run(4);
            btn_enter = 1'b0;
            hex_sw    = ~digits[d];
            run(10);
            check($sformatf("t4_hex_hold_%0d", d), {4'h0, hex_in}, {4'h0, digits[d]});
        end

        // 5: lock_reset beats set; reset mid-count; set held through reset
        clear_counts();
        btn_reset = 1'b1;
        btn_set   = 1'b1;
        run(10);
        check("t5_lock_reset_pulses", 8'(cnt_r), 8'd1);
        check("t5_set_suppressed",    8'(cnt_s), 8'd0);
        btn_reset = 1'b0;
        btn_set   = 1'b0;
        run(10);
        clear_counts();
        btn_set = 1'b1;
        run(4);
        reset = 1'b1;
        run(2);
        check("t5_mid_reset_outs", {3'h0, enter, set, change, lock_reset, 1'b0}, 8'h00);
        check("t5_mid_reset_held", {4'h0, held}, 8'h00);
        check("t5_mid_reset_hex",  {4'h0, hex_in}, 8'h00);
        check("t5_mid_reset_count", 8'(cnt_s), 8'd0);
        reset = 1'b0;
        run(5);
        check("t5_after_reset_early", {7'h0, set}, 8'h00);
        tick();
        check("t5_after_reset_pulse", {7'h0, set}, 8'h01);
        tick();
        check("t5_after_reset_single", {7'h0, set}, 8'h00);
        btn_set = 1'b0;
        run(10);

        // reset on the edge a pulse would register suppresses it
        clear_counts();
        btn_enter = 1'b1;
        run(5);
        reset     = 1'b1;
        btn_enter = 1'b0;
        tick();
        check("t6_suppressed_pulse", {7'h0, enter}, 8'h00);
        reset = 1'b0;
        run(12);
        check("t6_no_late_pulse", 8'(cnt_e), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
